// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit codes, PT-5 constants, SRAM geometry and the
// write-back FSM state type.
package ternary_pkg;

  localparam int ACC_W     = 32;
  localparam int SRAM_AW   = 12;
  localparam int SRAM_DW   = 24;
  localparam int PT5_TRITS = 5;

  localparam logic [7:0] PT5_ZERO_BYTE = 8'h79;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WRITE,
    ST_DONE
  } wb_state_t;

  // Balanced trit to base-3 digit (trit + 1); the unused code 11 reads as zero.
  function automatic logic [1:0] trit_digit(input logic [1:0] trit);
    case (trit)
      TRIT_POS: trit_digit = 2'd2;
      TRIT_NEG: trit_digit = 2'd0;
      default:  trit_digit = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/pt5_packer.sv
// Combinational PT-5 encoder: five 2-bit trits to one byte in 0..242.
// Exact inverse of pt5_unpacker; trit 0 is the least significant base-3 digit.
module pt5_packer
  import ternary_pkg::*;
(
  input  logic [2*PT5_TRITS-1:0] trits,
  output logic [7:0]             pt5_byte
);

  always_comb begin
    pt5_byte = 8'(trit_digit(trits[1:0]))
             + 8'd3  * 8'(trit_digit(trits[3:2]))
             + 8'd9  * 8'(trit_digit(trits[5:4]))
             + 8'd27 * 8'(trit_digit(trits[7:6]))
             + 8'd81 * 8'(trit_digit(trits[9:8]));
  end

endmodule

// File: rtl/pt5_writeback_packer.sv
// Result write-back path: quantises accumulator beats to trits, packs five per
// PT-5 byte, three bytes per word, and writes words to SRAM at base + n*stride.
module pt5_writeback_packer #(
  parameter int ACC_W   = ternary_pkg::ACC_W,
  parameter int SRAM_AW = ternary_pkg::SRAM_AW,
  parameter int SRAM_DW = ternary_pkg::SRAM_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SRAM_AW-1:0]   base_addr,
  input  logic [7:0]           stride,
  input  logic [31:0]          threshold,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5*ACC_W-1:0]   in_data,
  input  logic                 in_last,
  output logic [SRAM_AW-1:0]   sram_waddr,
  output logic [SRAM_DW-1:0]   sram_wdata,
  output logic                 sram_we,
  input  logic                 sram_ready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          word_count
);

  import ternary_pkg::*;

  wb_state_t state, state_nxt;

  logic [SRAM_AW-1:0]     addr_q;
  logic [7:0]             stride_q;
  logic [30:0]            thr_q;
  logic [1:0]             byte_idx;
  logic [SRAM_DW-1:0]     word_q;
  logic                   last_seen;
  logic [15:0]            word_count_q;

  logic [2*PT5_TRITS-1:0] trit_vec;
  logic [7:0]             beat_byte;
  logic signed [ACC_W:0]  t_pos, t_neg;
  logic                   beat_fire, word_end;
  logic                   unused_thr_sign;

  assign unused_thr_sign = threshold[31];

  assign t_pos = $signed({{(ACC_W-30){1'b0}}, thr_q});
  assign t_neg = -t_pos;

  // One extra bit keeps -t representable even for t = 2^31-1.
  always_comb begin
    logic signed [ACC_W:0] v_ext;
    trit_vec = '0;
    v_ext    = '0;
    for (int i = 0; i < PT5_TRITS; i++) begin
      v_ext = $signed({in_data[i*ACC_W+ACC_W-1], in_data[i*ACC_W +: ACC_W]});
      if (v_ext > t_pos)
        trit_vec[2*i +: 2] = TRIT_POS;
      else if (v_ext < t_neg)
        trit_vec[2*i +: 2] = TRIT_NEG;
      else
        trit_vec[2*i +: 2] = TRIT_ZERO;
    end
  end

  pt5_packer u_packer (
    .trits    (trit_vec),
    .pt5_byte (beat_byte)
  );

  assign beat_fire = in_valid && (state == ST_RUN);
  assign word_end  = beat_fire && ((byte_idx == 2'd2) || in_last);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (word_end) state_nxt = ST_WRITE;
      ST_WRITE: if (sram_ready) state_nxt = last_seen ? ST_DONE : ST_RUN;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready   = (state == ST_RUN);
  assign sram_we    = (state == ST_WRITE);
  assign busy       = (state == ST_RUN) || (state == ST_WRITE);
  assign done       = (state == ST_DONE);
  assign sram_waddr = addr_q;
  assign sram_wdata = word_q;
  assign word_count = word_count_q;

  // The first byte of a word pre-fills the upper slots with the zero byte, so
  // a word closed early by in_last is already padded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      thr_q        <= '0;
      byte_idx     <= '0;
      word_q       <= '0;
      last_seen    <= 1'b0;
      word_count_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q       <= base_addr;
            stride_q     <= (stride == 8'd0) ? 8'd1 : stride;
            thr_q        <= threshold[30:0];
            word_count_q <= '0;
            last_seen    <= 1'b0;
            byte_idx     <= '0;
          end
        end
        ST_RUN: begin
          if (beat_fire) begin
            if (byte_idx == 2'd0)
              word_q <= {PT5_ZERO_BYTE, PT5_ZERO_BYTE, beat_byte};
            else
              word_q[8*byte_idx +: 8] <= beat_byte;
            byte_idx  <= word_end ? 2'd0 : byte_idx + 2'd1;
            last_seen <= in_last;
          end
        end
        ST_WRITE: begin
          if (sram_ready) begin
            word_count_q <= word_count_q + 16'd1;
            addr_q       <= addr_q + SRAM_AW'(stride_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pt5_writeback_packer.sv
// Scoreboard bench for pt5_writeback_packer: a bench-side quantiser/encoder
// predicts every SRAM write; writes are popped and checked as they commit.
module tb_pt5_writeback_packer;
  import ternary_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [11:0]  base_addr;
  logic [7:0]   stride;
  logic [31:0]  threshold;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] in_data;
  logic         in_last;
  logic [11:0]  sram_waddr;
  logic [23:0]  sram_wdata;
  logic         sram_we;
  logic         sram_ready = 1'b0;
  logic         busy;
  logic         done;
  logic [15:0]  word_count;

  pt5_writeback_packer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .stride(stride), .threshold(threshold), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_ready(sram_ready), .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [23:0] data;
    logic [29:0] trits;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  bit          rand_ready  = 1'b0;
  bit          ready_force = 1'b1;
  bit          m_busy      = 1'b0;
  logic [11:0] m_addr;
  logic [11:0] m_stride;
  logic [31:0] m_thr;
  int          m_idx;
  int          m_count;
  logic [23:0] m_word;
  logic [29:0] m_trits;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] quant(input logic [31:0] v, input logic [31:0] thr);
    longint sv, t;
    sv = longint'($signed(v));
    t  = longint'(thr[30:0]);
    if (sv > t)       return TRIT_POS;
    else if (sv < -t) return TRIT_NEG;
    else              return TRIT_ZERO;
  endfunction

  function automatic logic [7:0] encode(input logic [9:0] tr);
    int s, w, d;
    s = 0; w = 1;
    for (int k = 0; k < 5; k++) begin
      case (tr[2*k +: 2])
        TRIT_POS: d = 2;
        TRIT_NEG: d = 0;
        default:  d = 1;
      endcase
      s += d * w;
      w *= 3;
    end
    return 8'(s);
  endfunction

  function automatic logic [9:0] decode(input logic [7:0] b);
    int v, d;
    logic [9:0] tr;
    v = int'(b);
    tr = '0;
    for (int k = 0; k < 5; k++) begin
      d = v % 3;
      v = v / 3;
      tr[2*k +: 2] = (d == 0) ? TRIT_NEG : (d == 2) ? TRIT_POS : TRIT_ZERO;
    end
    return tr;
  endfunction

  function automatic logic [159:0] beat5(input int a, input int b, input int c, input int d, input int e);
    return {32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  always @(posedge clk) begin
    #2;
    sram_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Every write request is compared to the head of the scoreboard while held;
  // it is popped and round-tripped through a PT-5 decode when it commits.
  always @(negedge clk) begin
    if (sram_we) begin
      checkOutput("in_ready_in_write", 64'(in_ready), 64'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 64'(sram_waddr), 64'hFFFF);
      end else begin
        checkOutput("waddr", 64'(sram_waddr), 64'(sb[0].addr));
        checkOutput("wdata", 64'(sram_wdata), 64'(sb[0].data));
        if (sram_ready) begin
          for (int k = 0; k < 3; k++)
            checkOutput("roundtrip", 64'(decode(sram_wdata[8*k +: 8])), 64'(sb[0].trits[10*k +: 10]));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic startJob(input logic [11:0] base, input logic [7:0] str, input logic [31:0] thr);
    @(negedge clk);
    start = 1'b1; base_addr = base; stride = str; threshold = thr;
    @(negedge clk);
    start = 1'b0;
    if (!m_busy) begin
      m_busy   = 1'b1;
      m_addr   = base;
      m_stride = (str == 8'd0) ? 12'd1 : 12'(str);
      m_thr    = thr;
      m_idx    = 0;
      m_count  = 0;
      checkOutput("busy_after_start", 64'(busy), 64'd1);
    end
  endtask

  task automatic applyStimulus(input logic [159:0] data, input bit last);
    int n;
    logic [9:0] tr;
    logic [7:0] b;
    @(negedge clk);
    in_valid = 1'b1; in_data = data; in_last = last;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int e = 0; e < 5; e++) tr[2*e +: 2] = quant(data[32*e +: 32], m_thr);
    b = encode(tr);
    if (m_idx == 0) begin
      m_word  = {8'h79, 8'h79, b};
      m_trits = {10'h0, 10'h0, tr};
    end else begin
      m_word[8*m_idx +: 8]   = b;
      m_trits[10*m_idx +: 10] = tr;
    end
    if (m_idx == 2 || last) begin
      sb.push_back('{addr: m_addr, data: m_word, trits: m_trits});
      m_addr  = m_addr + m_stride;
      m_count = m_count + 1;
      m_idx   = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checkOutput("done_timeout", 64'd0, 64'd1);
    end else begin
      checkOutput("word_count", 64'(word_count), 64'(m_count));
      checkOutput("busy_at_done", 64'(busy), 64'd0);
      checkOutput("sb_empty", 64'(sb.size()), 64'd0);
      @(negedge clk);
      checkOutput("done_pulse", 64'(done), 64'd0);
    end
    m_busy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nb, v[5];
    reset = 1'b1; start = 1'b0; base_addr = '0; stride = '0; threshold = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_we", 64'(sram_we), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_word_count", 64'(word_count), 64'd0);
    checkOutput("rst_waddr", 64'(sram_waddr), 64'd0);
    checkOutput("rst_wdata", 64'(sram_wdata), 64'd0);
    reset = 1'b0;

    in_valid = 1'b1; in_data = beat5(7, 7, 7, 7, 7);
    repeat (4) begin
      @(negedge clk);
      checkOutput("idle_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;

    startJob(12'h010, 8'd1, 32'd0);
    applyStimulus(beat5(5, 5, 5, 5, 5), 1'b0);
    applyStimulus(beat5(5, 5, 5, 5, 5), 1'b0);
    applyStimulus(beat5(5, 5, 5, 5, 5), 1'b1);
    waitDone();

    startJob(12'h020, 8'd1, 32'd5);
    applyStimulus(beat5(10, -10, 3, -3, 0), 1'b1);
    waitDone();

    startJob(12'h100, 8'd3, 32'd0);
    repeat (3) applyStimulus(beat5(0, 0, 0, 0, 0), 1'b0);
    applyStimulus(beat5(0, 0, 0, 0, 0), 1'b1);
    waitDone();

    ready_force = 1'b0;
    startJob(12'h200, 8'd1, 32'd0);
    applyStimulus(beat5(1, -1, 0, 2, -2), 1'b0);
    applyStimulus(beat5(-4, 4, 0, 0, 9), 1'b0);
    applyStimulus(beat5(0, 0, -1, 1, 0), 1'b1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("we_held", 64'(sram_we), 64'd1);
    end
    ready_force = 1'b1;
    waitDone();

    startJob(12'hFFF, 8'd2, 32'd0);
    applyStimulus(beat5(3, 3, -3, -3, 0), 1'b0);
    startJob(12'h555, 8'd9, 32'd100);
    for (int i = 1; i < 5; i++) applyStimulus(beat5(i, -i, 0, i, -i), 1'b0);
    applyStimulus(beat5(-8, 8, -8, 8, 0), 1'b1);
    waitDone();

    startJob(12'h300, 8'd0, 32'd0);
    repeat (3) applyStimulus(beat5(1, 1, 1, 1, 1), 1'b0);
    applyStimulus(beat5(-1, -1, -1, -1, -1), 1'b1);
    waitDone();

    startJob(12'h050, 8'd1, 32'hFFFF_FFFF);
    applyStimulus({32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 32'h8000_0000}, 1'b1);
    waitDone();

    startJob(12'h400, 8'd1, 32'd0);
    applyStimulus(beat5(5, 5, 5, 5, 5), 1'b0);
    applyStimulus(beat5(5, 5, 5, 5, 5), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_we", 64'(sram_we), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    checkOutput("postrst_we", 64'(sram_we), 64'd0);
    startJob(12'h600, 8'd1, 32'd0);
    applyStimulus(beat5(-5, 5, -5, 5, 0), 1'b0);
    applyStimulus(beat5(0, 0, 0, 0, 0), 1'b0);
    applyStimulus(beat5(9, 9, 9, 9, 9), 1'b1);
    waitDone();

    rand_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      startJob(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)), 32'($urandom_range(0, 20)));
      nb = $urandom_range(1, 7);
      for (int i = 0; i < nb; i++) begin
        for (int e = 0; e < 5; e++) v[e] = int'($urandom_range(0, 60)) - 30;
        applyStimulus(beat5(v[0], v[1], v[2], v[3], v[4]), i == nb - 1);
      end
      waitDone();
    end
    rand_ready = 1'b0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
